sub2_chan_fifo: RTL
===================

// Module: sub2_chan_fifo
// PURPOSE
// - Multi-channel elastic buffer, NCH independent channels of W-bit data.
// - Each channel is a DEPTH-entry FIFO with a valid/ready handshake on both sides.
// - Input data arrives as a 2D packed array; output data leaves as a 2D unpacked array.
// - Sits between port-array producers/consumers; absorbs per-channel backpressure without cross-channel coupling.
// PARAMETERS
// - NCH   = 3 : number of channels, >=1
// - W     = 8 : data width per channel, >=1
// - DEPTH = 4 : entries per channel, >=1 (need not be a power of 2)
// - LW    = $clog2(DEPTH+1) : level width (localparam, derived)
// PORTS
// - clk        input   1                 : clock, rising edge
// - rst_n      input   1                 : async active-low reset
// - flush      input   1                 : sync clear of all channels
// - in_valid   input   [NCH-1:0]         : per-channel push request
// - in_ready   output  [NCH-1:0]         : per-channel space available
// - in_data    input   [0:NCH-1][W-1:0]  : packed array, element i = channel i
// - out_valid  output  [NCH-1:0]         : per-channel head valid
// - out_ready  input   [NCH-1:0]         : per-channel pop accept
// - out_data   output  [W-1:0] [0:NCH-1] : unpacked array, head entry of channel i
// - level      output  [0:NCH-1][LW-1:0] : per-channel occupancy, 0..DEPTH
// BEHAVIOUR
// - Interface: one clock (clk); reset rst_n is asynchronous, active-low.
// - Reset values:
//   - level = 0; out_valid = 0; in_ready = all 1s; out_data = 0 (storage and pointers cleared).
// - Transfers:
//   - push[i] = in_valid[i] & in_ready[i]
//   - pop[i]  = out_valid[i] & out_ready[i]
//   - Both take effect at the clk edge.
// - Handshake outputs:
//   - in_ready[i]  = (level[i] != DEPTH); no dependence on out_ready (no pass-through when full).
//   - out_valid[i] = (level[i] != 0).
//   - Both are pure functions of registered state.
// - Latency: a word pushed into an empty channel appears on out_data/out_valid the next cycle. No same-cycle bypass.
// - out_data[i] = storage[i][rd_ptr[i]]. It holds stable while out_valid[i] & !out_ready[i].
// - Level update:
//   - push & pop: level unchanged; both pointers advance.
//   - push only: +1. pop only: -1.
// - Pointers wrap DEPTH-1 -> 0 explicitly (modulo DEPTH, not modulo 2^n).
// - Full channel: in_valid is ignored and data is not written. A simultaneous pop frees space for the next cycle only.
// - Empty channel: out_ready is ignored; level never underflows.
// - flush:
//   - Next edge: all levels = 0, all pointers = 0. Storage contents are don't-care.
//   - Overrides a push/pop in the same cycle; that push is dropped.
// - Reset mid-operation: all channel contents are discarded immediately (async). Outputs reach reset values without waiting for clk.
// - Channels are fully independent; no arbitration or shared state.
// CONFIGURATION
// - Macro SUB2_CHAN_FIFO_STATS_EN:
//   - When defined, adds output `drop_cnt [0:NCH-1][15:0]`.
//     - Increments on in_valid[i] & !in_ready[i] (rejected push) or a push dropped by flush.
//     - Saturates at 16'hFFFF.
//     - Cleared by rst_n only; flush does not clear it.
//   - When not defined: the port and its counters are absent. Handshake timing is identical either way.
// TESTING
// - T1 reset/empty:
//   - Stimulus: assert rst_n=0 mid-stream.
//   - Expect: immediately level=0, out_valid=0, in_ready=3'b111, out_data all 0.
// - T2 fill/full (ch0, DEPTH=4):
//   - Stimulus: push 0x11,0x22,0x33,0x44, out_ready=0.
//   - Expect: level[0]=4, in_ready[0]=0. A 5th push of 0x55 is rejected; drop_cnt[0]=1 if STATS_EN.
// - T3 drain order:
//   - Stimulus: from T2, hold out_ready[0]=1 for 4 cycles.
//   - Expect: out_data[0] = 0x11,0x22,0x33,0x44, then out_valid[0]=0 and level[0]=0.
// - T4 wrap and concurrent push/pop:
//   - Stimulus: keep level[1]=2, push and pop every cycle for 10 cycles.
//   - Expect: level stays 2; data in order across pointer wrap (3->0).
// - T5 flush:
//   - Stimulus: ch2 level=3, assert flush with in_valid[2]=1.
//   - Expect next cycle: level[2]=0, out_valid[2]=0, pushed word absent.
// - T6 independence:
//   - Stimulus: ch0 stalled full while ch1 and ch2 stream.
//   - Expect: ch1/ch2 throughput of 1 word/cycle, with no data corruption.

Source files
------------

// File: rtl/sub2_chan_fifo.sv
// NCH independent DEPTH-entry valid/ready FIFOs; data appears one cycle after push, no bypass.
// Optional macro SUB2_CHAN_FIFO_STATS_EN adds saturating per-channel drop counters (drop_cnt).
module sub2_chan_fifo #(
  parameter  int NCH   = 3,
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NCH-1:0]            in_valid,
  output logic [NCH-1:0]            in_ready,
  input  logic [0:NCH-1][W-1:0]     in_data,
  output logic [NCH-1:0]            out_valid,
  input  logic [NCH-1:0]            out_ready,
  output logic [W-1:0]              out_data [0:NCH-1],
  output logic [0:NCH-1][LW-1:0]    level
`ifdef SUB2_CHAN_FIFO_STATS_EN
  ,
  output logic [0:NCH-1][15:0]      drop_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q    [NCH][DEPTH];
  logic [W-1:0]  mem_d    [NCH][DEPTH];
  logic [PW-1:0] rd_ptr_q [NCH];
  logic [PW-1:0] rd_ptr_d [NCH];
  logic [PW-1:0] wr_ptr_q [NCH];
  logic [PW-1:0] wr_ptr_d [NCH];
  logic [LW-1:0] level_q  [NCH];
  logic [LW-1:0] level_d  [NCH];
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      in_ready[i]  = (level_q[i] != LW'(DEPTH));
      out_valid[i] = (level_q[i] != '0);
      out_data[i]  = mem_q[i][rd_ptr_q[i]];
      level[i]     = level_q[i];
      push[i]      = in_valid[i] & in_ready[i];
      pop[i]       = out_valid[i] & out_ready[i];
    end
  end

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    for (int i = 0; i < NCH; i++) begin
      if (flush) begin
        rd_ptr_d[i] = '0;
        wr_ptr_d[i] = '0;
        level_d[i]  = '0;
      end else begin
        if (push[i]) begin
          mem_d[i][wr_ptr_q[i]] = in_data[i];
          wr_ptr_d[i]           = ptr_inc(wr_ptr_q[i]);
        end
        if (pop[i]) begin
          rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
        end
        case ({push[i], pop[i]})
          2'b10:   level_d[i] = level_q[i] + LW'(1);
          2'b01:   level_d[i] = level_q[i] - LW'(1);
          default: level_d[i] = level_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        level_q[i]  <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
      end
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

`ifdef SUB2_CHAN_FIFO_STATS_EN
  logic [15:0] drop_cnt_q [NCH];
  logic [15:0] drop_cnt_d [NCH];

  // A drop is either a push refused for lack of space or an accepted push cancelled by flush.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      drop_cnt_d[i] = drop_cnt_q[i];
      if (((in_valid[i] & ~in_ready[i]) | (flush & push[i])) && (drop_cnt_q[i] != 16'hFFFF)) begin
        drop_cnt_d[i] = drop_cnt_q[i] + 16'd1;
      end
      drop_cnt[i] = drop_cnt_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        drop_cnt_q[i] <= '0;
      end
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif

endmodule
